dac_ad5318_sequencer: RTL and testbench
=======================================

// Module: dac_ad5318_sequencer
// PURPOSE
// - Upstream controller for the ad5318 SPI serializer. Drives its tdata/tuser/tvalid/tready stream.
// - After reset it sends the reference-setup and power-up control words.
// - It then arbitrates eight per-channel update requests round-robin and emits one data word per grant.
// - Each batch of data words ends with one LDAC single-update control word.
// PARAMETERS
// - STARTUP_CYC  200      clkin cycles between reset release and the first config word.
// - MAX_BATCH    8        max data words before a forced LDAC word (1..8).
// - CMD_REF      16'h8030 reference/gain/buffer control word.
// - CMD_PWR      16'hC000 power-up-all-channels control word.
// - CMD_LDAC     16'hA002 LDAC single-update control word.
// PORTS
// - clkin     in   1   system clock, all logic on rising edge.
// - rstn      in   1   reset, asynchronous, active-low.
// - ch_req    in   8   per-channel update request; level, held until ch_ack.
// - ch_code   in   80  10-bit codes; channel i = ch_code[10*i+9:10*i]; sampled at grant.
// - ch_ack    out  8   one-cycle pulse when channel i's data word is accepted downstream.
// - upd_done  out  1   one-cycle pulse when the LDAC word is accepted.
// - init_done out  1   level; high once CMD_PWR is accepted.
// - busy      out  1   high in every state except IDLE.
// - tdata     out  16  word to the serializer.
// - tuser     out  3   channel index for data words; 3'd0 for control words.
// - tvalid    out  1   word valid.
// - tready    in   1   serializer ready; a word transfers when tvalid & tready.
// BEHAVIOUR
// - Reset values: tdata=0, tuser=0, tvalid=0, ch_ack=0, upd_done=0, init_done=0, busy=1.
//   State returns to WAIT_START; RR pointer = 7, so channel 0 has first priority.
// - FSM states:
//   - WAIT_START: count STARTUP_CYC cycles, then go to SEND_REF.
//   - SEND_REF: present CMD_REF; on handshake go to SEND_PWR.
//   - SEND_PWR: present CMD_PWR; on handshake set init_done and go to IDLE.
//   - IDLE: if any ch_req, register the grant and go to SEND_DATA.
//   - SEND_DATA: on handshake pulse ch_ack[g] and increment batch_cnt.
//     Go back to SEND_DATA with a new grant if any other request is pending and batch_cnt < MAX_BATCH; otherwise go to SEND_LDAC.
//   - SEND_LDAC: present CMD_LDAC; on handshake pulse upd_done, clear batch_cnt, go to IDLE.
// - Latency: a request seen in IDLE at edge N gives tvalid=1 after edge N+1.
//   Back-to-back words have zero bubble: the next word is loaded on the handshake edge.
// - Data word: tdata = {1'b0, g[2:0], code[9:0], 2'b00}; tuser = g.
// - Handshake: while tvalid=1 and tready=0, tdata and tuser hold stable, with no timeout.
//   tvalid drops only after a handshake with no next word.
// - Arbitration: search starts at (ptr+1) mod 8 and wraps 7->0. ptr = g on grant.
//   The requester whose data word was just accepted is excluded from that cycle's next-grant search.
//   ch_code is captured at grant; later changes go into the next request.
// - ch_req dropped before grant: ignored, no ack.
// - ch_req still high after its ack: treated as a new request, served after the LDAC of the current batch.
// - ch_req during WAIT_START/SEND_REF/SEND_PWR: held pending; no grant until IDLE.
// - rstn low mid-word: tvalid falls immediately (async). The config sequence restarts on release.
// STRUCTURE
// - Package dac_ad5318_pkg: state enum, default command words, NUM_CH=8, CODE_W=10, and a pack_data(ch, code) function.
// - Sub-module dac_rr_arbiter: 8-way round-robin arbiter.
//   - Inputs: req, ptr, exclude mask.
//   - Outputs: gnt_valid, gnt_idx.
//   - Purely combinational; the pointer register lives in the sequencer.
// TESTING
// 1. Reset, STARTUP_CYC=200, tready=1: 16'h8030 appears after 200 cycles, then 16'hC000; init_done rises; no tvalid before.
// 2. ch_req[4]=1, code 10'd1: tdata=16'h4004 with tuser=4, then 16'hA002; ch_ack[4] pulses once, then upd_done.
// 3. Last grant ch3; ch_req[2] and ch_req[5] raised together: order is 5 then 2 (wrap), then one LDAC word.
// 4. tready=0 for 20 cycles during a data word: tvalid stays 1, tdata/tuser stay constant; completes after tready=1.
// 5. MAX_BATCH=2, all 8 requesting, code=i*100: words ch0,ch1,LDAC,ch2,ch3,LDAC..., total 12 words.
// 6. rstn pulsed low in SEND_DATA with tready=0: tvalid=0 at once, no ch_ack; after release 8030/C000 are resent before any data.

Source files
------------

// File: rtl/dac_ad5318_pkg.sv
// Shared types, default command words and the data-word packer for the
// AD5318 upstream sequencer.
package dac_ad5318_pkg;

    localparam int unsigned NUM_CH = 8;
    localparam int unsigned CODE_W = 10;

    localparam logic [15:0] DEF_CMD_REF  = 16'h8030;
    localparam logic [15:0] DEF_CMD_PWR  = 16'hC000;
    localparam logic [15:0] DEF_CMD_LDAC = 16'hA002;

    typedef enum logic [2:0] {
        ST_WAIT_START,
        ST_SEND_REF,
        ST_SEND_PWR,
        ST_IDLE,
        ST_SEND_DATA,
        ST_SEND_LDAC
    } state_t;

    // Data word layout: control bit 0, DAC address, 10-bit code, two don't-care LSBs.
    function automatic logic [15:0] pack_data(input logic [2:0] ch, input logic [CODE_W-1:0] code);
        return {1'b0, ch, code, 2'b00};
    endfunction

endpackage

// File: rtl/dac_rr_arbiter.sv
// Combinational 8-way round-robin arbiter: the search starts one past i_ptr
// and wraps; channels set in i_excl are skipped.
module dac_rr_arbiter
    import dac_ad5318_pkg::*;
(
    input  logic [NUM_CH-1:0] i_req,
    input  logic [2:0]        i_ptr,
    input  logic [NUM_CH-1:0] i_excl,
    output logic              o_gnt_valid,
    output logic [2:0]        o_gnt_idx
);

    logic [NUM_CH-1:0] w_eff;
    logic [2:0]        w_idx;

    always_comb begin
        w_eff       = i_req & ~i_excl;
        o_gnt_valid = 1'b0;
        o_gnt_idx   = '0;
        w_idx       = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            w_idx = i_ptr + 3'(k);
            if (!o_gnt_valid && w_eff[w_idx]) begin
                o_gnt_valid = 1'b1;
                o_gnt_idx   = w_idx;
            end
        end
    end

endmodule

// File: rtl/dac_ad5318_sequencer.sv
// Upstream sequencer for the AD5318 SPI serializer: startup config words,
// round-robin per-channel data words, and an LDAC word closing each batch.
module dac_ad5318_sequencer
    import dac_ad5318_pkg::*;
#(
    parameter int unsigned STARTUP_CYC = 200,
    parameter int unsigned MAX_BATCH   = 8,
    parameter logic [15:0] CMD_REF     = DEF_CMD_REF,
    parameter logic [15:0] CMD_PWR     = DEF_CMD_PWR,
    parameter logic [15:0] CMD_LDAC    = DEF_CMD_LDAC
) (
    input  logic                     clkin,
    input  logic                     rstn,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH*CODE_W-1:0] ch_code,
    output logic [NUM_CH-1:0]        ch_ack,
    output logic                     upd_done,
    output logic                     init_done,
    output logic                     busy,
    output logic [15:0]              tdata,
    output logic [2:0]               tuser,
    output logic                     tvalid,
    input  logic                     tready
);

    state_t            r_state;
    logic [31:0]       r_start_cnt;
    logic [2:0]        r_ptr;
    logic [3:0]        r_batch_cnt;
    logic [NUM_CH-1:0] r_served;
    logic [NUM_CH-1:0] r_ch_ack;
    logic              r_upd_done;
    logic              r_init_done;
    logic              r_busy;
    logic [15:0]       r_tdata;
    logic [2:0]        r_tuser;
    logic              r_tvalid;

    logic              w_hs;
    logic              w_gnt_valid;
    logic [2:0]        w_gnt_idx;
    logic [CODE_W-1:0] w_code;
    logic [3:0]        w_batch_nxt;

    assign w_hs        = r_tvalid & tready;
    assign w_code      = ch_code[w_gnt_idx*CODE_W +: CODE_W];
    assign w_batch_nxt = r_batch_cnt + 4'd1;

    // Channels already served in this batch stay masked until LDAC, so a
    // request held past its ack waits for the next batch.
    dac_rr_arbiter u_arb (
        .i_req       (ch_req),
        .i_ptr       (r_ptr),
        .i_excl      (r_served),
        .o_gnt_valid (w_gnt_valid),
        .o_gnt_idx   (w_gnt_idx)
    );

    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_WAIT_START;
            r_start_cnt <= '0;
            r_ptr       <= 3'd7;
            r_batch_cnt <= '0;
            r_served    <= '0;
            r_ch_ack    <= '0;
            r_upd_done  <= 1'b0;
            r_init_done <= 1'b0;
            r_busy      <= 1'b1;
            r_tdata     <= '0;
            r_tuser     <= '0;
            r_tvalid    <= 1'b0;
        end else begin
            r_ch_ack   <= '0;
            r_upd_done <= 1'b0;
            case (r_state)
                ST_WAIT_START: begin
                    if (r_start_cnt + 32'd1 >= STARTUP_CYC) begin
                        r_state  <= ST_SEND_REF;
                        r_tdata  <= CMD_REF;
                        r_tuser  <= '0;
                        r_tvalid <= 1'b1;
                    end else begin
                        r_start_cnt <= r_start_cnt + 32'd1;
                    end
                end
                ST_SEND_REF: begin
                    if (w_hs) begin
                        r_state <= ST_SEND_PWR;
                        r_tdata <= CMD_PWR;
                    end
                end
                ST_SEND_PWR: begin
                    if (w_hs) begin
                        r_state     <= ST_IDLE;
                        r_tvalid    <= 1'b0;
                        r_init_done <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    // Grant is registered here; the word goes valid on the next edge.
                    if (w_gnt_valid) begin
                        r_state             <= ST_SEND_DATA;
                        r_tdata             <= pack_data(w_gnt_idx, w_code);
                        r_tuser             <= w_gnt_idx;
                        r_ptr               <= w_gnt_idx;
                        r_served[w_gnt_idx] <= 1'b1;
                        r_busy              <= 1'b1;
                    end
                end
                ST_SEND_DATA: begin
                    if (!r_tvalid) begin
                        r_tvalid <= 1'b1;
                    end else if (w_hs) begin
                        r_ch_ack[r_tuser] <= 1'b1;
                        r_batch_cnt       <= w_batch_nxt;
                        if (w_gnt_valid && (w_batch_nxt < 4'(MAX_BATCH))) begin
                            r_tdata             <= pack_data(w_gnt_idx, w_code);
                            r_tuser             <= w_gnt_idx;
                            r_ptr               <= w_gnt_idx;
                            r_served[w_gnt_idx] <= 1'b1;
                        end else begin
                            r_state <= ST_SEND_LDAC;
                            r_tdata <= CMD_LDAC;
                            r_tuser <= '0;
                        end
                    end
                end
                ST_SEND_LDAC: begin
                    if (w_hs) begin
                        r_state     <= ST_IDLE;
                        r_tvalid    <= 1'b0;
                        r_upd_done  <= 1'b1;
                        r_batch_cnt <= '0;
                        r_served    <= '0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_WAIT_START;
                    r_tvalid <= 1'b0;
                end
            endcase
        end
    end

    assign ch_ack    = r_ch_ack;
    assign upd_done  = r_upd_done;
    assign init_done = r_init_done;
    assign busy      = r_busy;
    assign tdata     = r_tdata;
    assign tuser     = r_tuser;
    assign tvalid    = r_tvalid;

endmodule

// File: tb/tb_dac_ad5318_sequencer.sv
// Testbench for dac_ad5318_sequencer: vector table, hand-written corner
// sequences and randomized rounds checked against a word-order model.
module tb_dac_ad5318_sequencer;

    localparam int unsigned TB_STARTUP   = 200;
    localparam int unsigned TB_MAX_BATCH = 2;

    logic        clkin;
    logic        rstn;
    logic [7:0]  ch_req;
    logic [79:0] ch_code;
    logic [7:0]  ch_ack;
    logic        upd_done;
    logic        init_done;
    logic        busy;
    logic [15:0] tdata;
    logic [2:0]  tuser;
    logic        tvalid;
    logic        tready;

    typedef struct packed {
        logic [15:0] d;
        logic [2:0]  u;
    } word_t;

    typedef struct {
        logic [2:0]  ch;
        logic [9:0]  code;
        logic [15:0] exp_d;
    } vec_t;

    word_t       got_q[$];
    word_t       exp_q[$];
    vec_t        vecs[6];
    int          n_checks = 0;
    int          n_errors = 0;
    int          ack_cnt[8];
    int          upd_cnt;
    int          exp_upd;
    int unsigned model_last;
    bit          rand_ready;
    logic        hold_v;
    logic [15:0] hold_d;
    logic [2:0]  hold_u;

    dac_ad5318_sequencer #(
        .STARTUP_CYC (TB_STARTUP),
        .MAX_BATCH   (TB_MAX_BATCH)
    ) dut (
        .clkin     (clkin),
        .rstn      (rstn),
        .ch_req    (ch_req),
        .ch_code   (ch_code),
        .ch_ack    (ch_ack),
        .upd_done  (upd_done),
        .init_done (init_done),
        .busy      (busy),
        .tdata     (tdata),
        .tuser     (tuser),
        .tvalid    (tvalid),
        .tready    (tready)
    );

    initial begin
        clkin = 1'b0;
        forever #5 clkin = ~clkin;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    // Sample at negedge, then advance past the next rising edge; the requester
    // drops a request once its ack is visible.
    task automatic step();
        @(negedge clkin);
        if (rstn && tvalid && tready) got_q.push_back('{d: tdata, u: tuser});
        if (hold_v && tvalid) begin
            check("hold_tdata", 32'(tdata), 32'(hold_d));
            check("hold_tuser", 32'(tuser), 32'(hold_u));
        end
        hold_v = rstn && tvalid && !tready;
        hold_d = tdata;
        hold_u = tuser;
        for (int i = 0; i < 8; i++) if (ch_ack[i]) ack_cnt[i]++;
        if (upd_done) upd_cnt++;
        @(posedge clkin);
        #1;
        ch_req = ch_req & ~ch_ack;
        if (rand_ready) tready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic clear();
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < 8; i++) ack_cnt[i] = 0;
        upd_cnt = 0;
        exp_upd = 0;
    endtask

    // Expected word stream: requested channels in rotating order after the
    // last grant, an LDAC after every MAX_BATCH words and after the last one.
    task automatic model_round(input logic [7:0] mask, input logic [79:0] codes);
        int unsigned order[$];
        for (int unsigned k = 1; k <= 8; k++) begin
            int unsigned c = (model_last + k) % 8;
            if (mask[c]) order.push_back(c);
        end
        for (int unsigned j = 0; j < order.size(); j++) begin
            int unsigned c    = order[j];
            int unsigned code = 32'(codes[c*10 +: 10]);
            exp_q.push_back('{d: 16'(c * 4096 + code * 4), u: 3'(c)});
            if (((j + 1) % TB_MAX_BATCH == 0) || (j + 1 == order.size())) begin
                exp_q.push_back('{d: 16'hA002, u: 3'd0});
                exp_upd++;
            end
        end
        if (order.size() > 0) model_last = order[order.size() - 1];
    endtask

    task automatic drain(input string name, input int budget);
        int cyc = 0;
        while (cyc < budget && !(ch_req == 8'h00 && !busy)) begin
            step();
            cyc++;
        end
        check({name, "_drain_in_budget"}, 32'(cyc < budget), 32'd1);
        step();
    endtask

    task automatic verify(input string name, input logic [7:0] mask);
        check({name, "_nwords"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_w%0d_tdata", name, i), 32'(got_q[i].d), 32'(exp_q[i].d));
            check($sformatf("%s_w%0d_tuser", name, i), 32'(got_q[i].u), 32'(exp_q[i].u));
        end
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_ack%0d", name, i), 32'(ack_cnt[i]), 32'(mask[i]));
        check({name, "_upd_done"}, 32'(upd_cnt), 32'(exp_upd));
    endtask

    task automatic wait_valid(input string name);
        int w = 0;
        while (!tvalid && w < 10) begin
            step();
            w++;
        end
        check({name, "_tvalid"}, 32'(tvalid), 32'd1);
    endtask

    initial begin
        vecs[0] = '{3'd4, 10'd1,    16'h4004};
        vecs[1] = '{3'd0, 10'd0,    16'h0000};
        vecs[2] = '{3'd7, 10'd1023, 16'h7FFC};
        vecs[3] = '{3'd2, 10'd512,  16'h2800};
        vecs[4] = '{3'd5, 10'h155,  16'h5554};
        vecs[5] = '{3'd3, 10'd3,    16'h300C};

        rstn       = 1'b0;
        tready     = 1'b1;
        ch_req     = '0;
        ch_code    = '0;
        rand_ready = 1'b0;
        hold_v     = 1'b0;
        hold_d     = '0;
        hold_u     = '0;
        model_last = 7;
        clear();

        repeat (3) @(posedge clkin);
        #1;
        check("rst_tdata", 32'(tdata), 32'h0);
        check("rst_tuser", 32'(tuser), 32'h0);
        check("rst_tvalid", 32'(tvalid), 32'h0);
        check("rst_ch_ack", 32'(ch_ack), 32'h0);
        check("rst_upd_done", 32'(upd_done), 32'h0);
        check("rst_init_done", 32'(init_done), 32'h0);
        check("rst_busy", 32'(busy), 32'h1);
        rstn = 1'b1;

        // Startup: first word after exactly STARTUP_CYC edges, then REF, PWR.
        begin
            int cyc = 0;
            while (!tvalid && cyc < 1000) begin
                step();
                cyc++;
            end
            check("startup_cycles", 32'(cyc), 32'(TB_STARTUP));
        end
        exp_q.push_back('{d: 16'h8030, u: 3'd0});
        exp_q.push_back('{d: 16'hC000, u: 3'd0});
        drain("config", 50);
        verify("config", 8'h00);
        check("init_done", 32'(init_done), 32'h1);
        check("idle_busy", 32'(busy), 32'h0);

        // Single-channel vectors; the first also checks grant-to-valid latency.
        for (int v = 0; v < 6; v++) begin
            clear();
            ch_code[32'(vecs[v].ch)*10 +: 10] = vecs[v].code;
            ch_req[vecs[v].ch] = 1'b1;
            if (v == 0) begin
                step();
                check("lat_edge_n_tvalid", 32'(tvalid), 32'h0);
                step();
                check("lat_edge_n1_tvalid", 32'(tvalid), 32'h1);
            end
            drain($sformatf("vec%0d", v), 100);
            exp_q.push_back('{d: vecs[v].exp_d, u: vecs[v].ch});
            exp_q.push_back('{d: 16'hA002, u: 3'd0});
            exp_upd = 1;
            verify($sformatf("vec%0d", v), 8'(1 << vecs[v].ch));
            model_last = 32'(vecs[v].ch);
        end

        // Last grant was ch3: ch2 and ch5 together must go 5 then 2.
        clear();
        ch_code[50 +: 10] = 10'd7;
        ch_code[20 +: 10] = 10'd9;
        ch_req = ch_req | 8'h24;
        drain("wrap", 100);
        exp_q.push_back('{d: 16'h501C, u: 3'd5});
        exp_q.push_back('{d: 16'h2024, u: 3'd2});
        exp_q.push_back('{d: 16'hA002, u: 3'd0});
        exp_upd = 1;
        verify("wrap", 8'h24);
        model_last = 2;

        // Backpressure for 20 cycles; code change after grant must not leak in.
        clear();
        tready = 1'b0;
        ch_code[70 +: 10] = 10'd100;
        ch_req[7] = 1'b1;
        wait_valid("stall");
        for (int i = 0; i < 20; i++) begin
            if (i == 5) ch_code[70 +: 10] = 10'd999;
            step();
            check("stall_tvalid", 32'(tvalid), 32'h1);
            check("stall_tdata", 32'(tdata), 32'h7190);
            check("stall_tuser", 32'(tuser), 32'h7);
            check("stall_no_ack", 32'(ch_ack), 32'h0);
        end
        tready = 1'b1;
        drain("stall", 100);
        exp_q.push_back('{d: 16'h7190, u: 3'd7});
        exp_q.push_back('{d: 16'hA002, u: 3'd0});
        exp_upd = 1;
        verify("stall", 8'h80);
        model_last = 7;

        // All eight requesting with batches of two.
        clear();
        for (int i = 0; i < 8; i++) ch_code[i*10 +: 10] = 10'(i * 100);
        model_round(8'hFF, ch_code);
        ch_req = 8'hFF;
        drain("all8", 300);
        check("all8_total_words", 32'(got_q.size()), 32'd12);
        verify("all8", 8'hFF);

        // Randomized rounds with random backpressure.
        rand_ready = 1'b1;
        for (int r = 0; r < 30; r++) begin
            logic [7:0] mask;
            clear();
            for (int i = 0; i < 8; i++) ch_code[i*10 +: 10] = 10'($urandom);
            mask = 8'($urandom_range(1, 255));
            model_round(mask, ch_code);
            ch_req = ch_req | mask;
            drain($sformatf("rnd%0d", r), 600);
            verify($sformatf("rnd%0d", r), mask);
        end
        rand_ready = 1'b0;
        tready     = 1'b1;

        // Reset mid-word: tvalid drops at once, config replays before data.
        clear();
        tready = 1'b0;
        ch_code[20 +: 10] = 10'd5;
        ch_req[2] = 1'b1;
        wait_valid("rstmid");
        rstn = 1'b0;
        #1;
        check("rstmid_tvalid", 32'(tvalid), 32'h0);
        check("rstmid_ch_ack", 32'(ch_ack), 32'h0);
        check("rstmid_init_done", 32'(init_done), 32'h0);
        step();
        step();
        clear();
        rstn   = 1'b1;
        tready = 1'b1;
        model_last = 7;
        exp_q.push_back('{d: 16'h8030, u: 3'd0});
        exp_q.push_back('{d: 16'hC000, u: 3'd0});
        model_round(8'h04, ch_code);
        drain("rstmid", 400);
        verify("rstmid", 8'h04);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
